cell_bist2: RTL and testbench

CELL_BIST2 -- requirements
Module: cell_bist2

---
 rtl/cell_bist2.sv | 172 +++++++++++++++++
 tb/tb_cell_bist2.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_bist2.sv
// Two-input cell BIST: walks {A,B} through 00,01,10,11 for NLOOP passes and counts Y mismatches.
// Optional macro CELL_BIST_YSYNC_EN adds a 2-flop synchronizer on Y and a SYNC hold state.
module cell_bist2 #(
  parameter int NLOOP = 1,
  parameter int CNTW  = 8
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            START,
  input  logic [3:0]      TRUTH,
  input  logic [3:0]      SETTLE,
  output logic            A,
  output logic            B,
  input  logic            Y,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [CNTW-1:0] ERRCNT
);

`ifdef CELL_BIST_YSYNC_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SYNC,
    S_SAMPLE,
    S_FIN
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_FIN
  } state_t;
`endif

  localparam logic [7:0]      PASS_LAST = 8'(NLOOP - 1);
  localparam logic [CNTW-1:0] ERR_MAX   = '1;

  state_t     state;
  logic [1:0] vec;
  logic [3:0] hold_cnt;
  logic [7:0] pass_cnt;
  logic [3:0] truth_q;
  logic [3:0] settle_q;

  logic       y_cmp;
  logic       last_hold;
  logic       mismatch;
  logic       last_vec;
  logic       last_pass;

`ifdef CELL_BIST_YSYNC_EN
  logic y_meta;
  logic y_sync;
  logic sync_cnt;

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      y_meta <= 1'b0;
      y_sync <= 1'b0;
    end else begin
      y_meta <= Y;
      y_sync <= y_meta;
    end
  end

  // The two SYNC cycles let the current vector's Y reach y_sync before it is judged.
  assign y_cmp     = y_sync;
  assign last_hold = (state == S_SYNC) && sync_cnt;
`else
  assign y_cmp     = Y;
  assign last_hold = (state == S_DRIVE) && (hold_cnt == settle_q);
`endif

  assign mismatch  = (y_cmp != truth_q[vec]);
  assign last_vec  = (vec == 2'd3);
  assign last_pass = (pass_cnt == PASS_LAST);

  assign A = vec[1];
  assign B = vec[0];

  // NOTE: every flop here, including the latched TRUTH/SETTLE copies, is cleared by the async
  // reset so an aborted run leaves no stale state behind.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state    <= S_IDLE;
      vec      <= 2'd0;
      hold_cnt <= 4'd0;
      pass_cnt <= 8'd0;
      truth_q  <= 4'd0;
      settle_q <= 4'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      ERRCNT   <= '0;
`ifdef CELL_BIST_YSYNC_EN
      sync_cnt <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout; the sample step below deliberately overrides the
      // per-state defaults because the last assignment in the block wins.
      case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            state    <= S_DRIVE;
            vec      <= 2'd0;
            hold_cnt <= 4'd0;
            pass_cnt <= 8'd0;
            ERRCNT   <= '0;
            PASS     <= 1'b0;
            BUSY     <= 1'b1;
            truth_q  <= TRUTH;
            settle_q <= SETTLE;
          end
        end

        S_DRIVE: begin
`ifdef CELL_BIST_YSYNC_EN
          if (hold_cnt == settle_q) begin
            state    <= S_SYNC;
            sync_cnt <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
`else
          if (!last_hold) hold_cnt <= hold_cnt + 4'd1;
`endif
        end

`ifdef CELL_BIST_YSYNC_EN
        S_SYNC: begin
          sync_cnt <= 1'b1;
        end
`endif

        // Extra cycle after the final sample so PASS is formed from the settled count.
        S_SAMPLE: begin
          state <= S_FIN;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          PASS  <= (ERRCNT == '0);
          vec   <= 2'd0;
        end

        S_FIN: begin
          DONE  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      if (last_hold) begin
        if (mismatch && (ERRCNT != ERR_MAX)) ERRCNT <= ERRCNT + CNTW'(1);
        hold_cnt <= 4'd0;
        if (last_vec && last_pass) begin
          state <= S_SAMPLE;
        end else begin
          state <= S_DRIVE;
          vec   <= vec + 2'd1;
          if (last_vec) pass_cnt <= pass_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cell_bist2.sv
// Self-checking bench for cell_bist2: directed runs plus randomized runs against a
// per-cycle reference built from vector order, hold length and mismatch counts.
module tb_cell_bist2;

`ifdef CELL_BIST_YSYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [3:0] truth, settle, ytab;

  logic       a0, b0, y0, busy0, done0, pass0;
  logic [7:0] errcnt0;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic [1:0] errcnt1;

  // The cell under test is a 2-input lookup table chosen per run.
  assign y0 = ytab[{a0, b0}];
  assign y1 = ytab[{a1, b1}];

  cell_bist2 #(.NLOOP(1), .CNTW(8)) u_dut (
    .CLK(clk), .R(rst_n), .START(start0), .TRUTH(truth), .SETTLE(settle),
    .A(a0), .B(b0), .Y(y0), .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERRCNT(errcnt0)
  );

  cell_bist2 #(.NLOOP(2), .CNTW(2)) u_sat (
    .CLK(clk), .R(rst_n), .START(start1), .TRUTH(truth), .SETTLE(settle),
    .A(a1), .B(b1), .Y(y1), .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERRCNT(errcnt1)
  );

  bit         sel;
  logic [1:0] ab_m;
  logic       busy_m, done_m, pass_m;
  int         err_m;

  always_comb begin
    if (sel) begin
      ab_m = {a1, b1}; busy_m = busy1; done_m = done1; pass_m = pass1; err_m = int'(errcnt1);
    end else begin
      ab_m = {a0, b0}; busy_m = busy0; done_m = done0; pass_m = pass0; err_m = int'(errcnt0);
    end
  end

  int n_cmp;
  int n_bad;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_start(input bit s, input logic v);
    if (s) start1 = v;
    else   start0 = v;
  endtask

  // One full run on the selected instance, checked every cycle from the START edge to idle.
  task automatic run_check(input bit s, input logic [3:0] tr, input logic [3:0] st,
                           input logic [3:0] yt, input int nloop, input int cntw,
                           input bit hold_start, input bit noise, input string tag);
    int hold, vcycles, exp_err;
    logic [1:0] exp_ab;
    logic exp_busy, exp_done, chk_ab;
    hold    = int'(st) + 1 + SYNC_EXTRA;
    vcycles = 4 * hold * nloop;
    exp_err = $countones(tr ^ yt) * nloop;
    if (exp_err > (1 << cntw) - 1) exp_err = (1 << cntw) - 1;

    @(negedge clk);
    sel = s; truth = tr; settle = st; ytab = yt;
    set_start(s, 1'b1);
    @(posedge clk); #1;

    n_cmp++;
    if (err_m !== 0 || pass_m !== 1'b0) begin
      n_bad++;
      $display("FAIL %s start_clear: errcnt=%0d pass=%b, want errcnt=0 pass=0", tag, err_m, pass_m);
    end

    for (int e = 0; e <= vcycles + 2; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      chk_ab = 1'b1; exp_ab = 2'b00;
      if (e < vcycles) begin
        exp_ab = 2'((e / hold) % 4); exp_busy = 1'b1; exp_done = 1'b0;
      end else if (e == vcycles) begin
        chk_ab = 1'b0; exp_busy = 1'b1; exp_done = 1'b0;
      end else if (e == vcycles + 1) begin
        chk_ab = 1'b0; exp_busy = 1'b0; exp_done = 1'b1;
      end else begin
        exp_busy = 1'b0; exp_done = 1'b0;
      end
      n_cmp++;
      if ((chk_ab && ab_m !== exp_ab) || busy_m !== exp_busy || done_m !== exp_done) begin
        n_bad++;
        $display("FAIL %s cycle%0d: ab=%b busy=%b done=%b, want ab=%b busy=%b done=%b",
                 tag, e, ab_m, busy_m, done_m, exp_ab, exp_busy, exp_done);
      end
      if (e >= vcycles + 1) begin
        n_cmp++;
        if (err_m !== exp_err || pass_m !== (exp_err == 0)) begin
          n_bad++;
          $display("FAIL %s result%0d: errcnt=%0d pass=%b, want errcnt=%0d pass=%b",
                   tag, e, err_m, pass_m, exp_err, (exp_err == 0));
        end
      end
      // Mid-run noise on TRUTH/SETTLE/START must be ignored, including START during FIN.
      if (noise && e <= vcycles + 1) begin
        truth  = 4'($urandom);
        settle = 4'($urandom);
        set_start(s, (e == vcycles + 1) ? 1'b1 : 1'($urandom));
      end else begin
        set_start(s, hold_start);
      end
    end
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({a0, b0, busy0, done0, pass0} !== 5'b0 || errcnt0 !== 8'd0 ||
        {a1, b1, busy1, done1, pass1} !== 5'b0 || errcnt1 !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: dut0 ab=%b busy=%b done=%b pass=%b err=%0d dut1 ab=%b busy=%b done=%b pass=%b err=%0d, want all 0",
               {a0, b0}, busy0, done0, pass0, errcnt0, {a1, b1}, busy1, done1, pass1, errcnt1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a0, b0, busy0, done0} !== 4'b0 || errcnt0 !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_idle: ab=%b busy=%b done=%b err=%0d, want 0", {a0, b0}, busy0, done0, errcnt0);
    end
  endtask

  task automatic test_and_pass;
    run_check(1'b0, 4'b1000, 4'd0, 4'b1000, 1, 8, 1'b0, 1'b0, "and_pass");
  endtask

  task automatic test_tied;
    run_check(1'b0, 4'b1000, 4'd0, 4'b1111, 1, 8, 1'b0, 1'b0, "tied1");
    run_check(1'b0, 4'b1111, 4'd0, 4'b0000, 1, 8, 1'b0, 1'b0, "tied0");
  endtask

  task automatic test_saturate;
    run_check(1'b1, 4'b0000, 4'd0, 4'b1111, 2, 2, 1'b0, 1'b0, "saturate");
  endtask

  task automatic test_settle;
    run_check(1'b0, 4'b1110, 4'd3, 4'b1110, 1, 8, 1'b0, 1'b0, "settle3_or");
    run_check(1'b0, 4'b0110, 4'd15, 4'b0110, 1, 8, 1'b0, 1'b0, "settle15_xor");
  endtask

  task automatic test_back_to_back;
    bit seen;
    run_check(1'b0, 4'b0001, 4'd1, 4'b0111, 1, 8, 1'b1, 1'b0, "b2b_first");
    @(posedge clk); #1;
    n_cmp++;
    if (busy0 !== 1'b1 || {a0, b0} !== 2'b00 || errcnt0 !== 8'd0 || pass0 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_restart: busy=%b ab=%b err=%0d pass=%b, want busy=1 ab=00 err=0 pass=0",
               busy0, {a0, b0}, errcnt0, pass0);
    end
    start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (done0) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || errcnt0 !== 8'd2 || pass0 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: done_seen=%b err=%0d pass=%b, want done_seen=1 err=2 pass=0",
               seen, errcnt0, pass0);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_abort;
    int hold;
    bit bad;
    hold = 3 + SYNC_EXTRA;
    @(negedge clk);
    sel = 1'b0; truth = 4'b1000; settle = 4'd2; ytab = 4'b1000; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (2 * hold + 1) @(posedge clk);
    #1;
    n_cmp++;
    if ({a0, b0} !== 2'b10 || busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_vec10: ab=%b busy=%b, want ab=10 busy=1", {a0, b0}, busy0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a0, b0, busy0, done0, pass0} !== 5'b0 || errcnt0 !== 8'd0) begin
      n_bad++;
      $display("FAIL abort_async: ab=%b busy=%b done=%b pass=%b err=%0d, want all 0",
               {a0, b0}, busy0, done0, pass0, errcnt0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (8 * hold) begin
      @(posedge clk); #1;
      if (done0 || busy0 || a0 || b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL abort_quiet: activity after reset, want idle with no DONE");
    end
  endtask

  task automatic test_random;
    bit s;
    for (int i = 0; i < 10; i++) begin
      s = (i % 3 == 2);
      if (s)
        run_check(1'b1, 4'($urandom), 4'($urandom_range(0, 6)), 4'($urandom), 2, 2, 1'b0, 1'b1, "rand_sat");
      else
        run_check(1'b0, 4'($urandom), 4'($urandom_range(0, 15)), 4'($urandom), 1, 8, 1'b0, 1'b1, "rand");
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    truth = 4'd0; settle = 4'd0; ytab = 4'd0; sel = 1'b0;
    test_reset;
    test_and_pass;
    test_tied;
    test_saturate;
    test_settle;
    test_back_to_back;
    test_reset_abort;
    test_and_pass;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
